// File: rtl/sme_pkg.sv
// Shared SME definitions: buffer limits, control chars, feeder states.
// Imported by the feeder, its memory and its interface users.
package sme_pkg;

  localparam int SME_STR_MAX = 32;
  localparam int SME_PAT_MAX = 8;

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_STAR   = 8'h2A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STR,
    ST_GAP,
    ST_PAT,
    ST_WAIT,
    ST_RES,
    ST_FIN
  } feeder_state_t;

endpackage

// File: rtl/sme_feeder_if.sv
// SME character stream, engine response and per-pattern result bus.
// master = feeder side, slave = engine/host side.
interface sme_feeder_if #(
  parameter int NPAT = 4
);
  localparam int PW = $clog2(NPAT);

  logic [7:0]    chardata;
  logic          isstring;
  logic          ispattern;
  logic          sme_valid;
  logic          sme_match;
  logic [4:0]    sme_match_idx;
  logic          res_valid;
  logic [PW-1:0] res_slot;
  logic          res_match;
  logic [4:0]    res_index;
  logic          res_timeout;

  modport master (
    output chardata, isstring, ispattern,
    output res_valid, res_slot, res_match,
    output res_index, res_timeout,
    input  sme_valid, sme_match, sme_match_idx
  );

  modport slave (
    input  chardata, isstring, ispattern,
    input  res_valid, res_slot, res_match,
    input  res_index, res_timeout,
    output sme_valid, sme_match, sme_match_idx
  );

endinterface

// File: rtl/sme_feeder_mem.sv
// String/pattern buffers and pattern length regs for the feeder.
// Ports: write port (we/sel/addr/data), comb reads str/pat, lens.
module sme_feeder_mem
  import sme_pkg::*;
#(
  parameter  int NPAT = 4,
  localparam int PW   = $clog2(NPAT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [1:0]           sel,
  input  logic [4:0]           addr,
  input  logic [7:0]           data,
  input  logic [4:0]           str_ra,
  output logic [7:0]           str_rd,
  input  logic [PW-1:0]        pat_slot,
  input  logic [2:0]           pat_ra,
  output logic [7:0]           pat_rd,
  output logic [NPAT-1:0][3:0] lens
);

  logic [7:0] str_mem [SME_STR_MAX];
  logic [7:0] pat_mem [NPAT*SME_PAT_MAX];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SME_STR_MAX; i++)
        str_mem[i] <= '0;
      for (int i = 0; i < NPAT*SME_PAT_MAX; i++)
        pat_mem[i] <= '0;
      lens <= '0;
    end else if (we) begin
      unique case (sel)
        2'b00: str_mem[addr] <= data;
        2'b01: pat_mem[addr[PW+2:0]] <= data;
        2'b10: lens[addr[PW-1:0]] <= data[3:0];
        default: ;
      endcase
    end
  end

  assign str_rd = str_mem[str_ra];
  assign pat_rd = pat_mem[{pat_slot, pat_ra}];

endmodule

// File: rtl/sme_feeder.sv
// Host-side SME driver: streams string then patterns, collects results.
// Ports: clk/reset, write port, str_len/num_pat/start, busy/done, bus.
module sme_feeder
  import sme_pkg::*;
#(
  parameter  int NPAT    = 4,
  parameter  int TIMEOUT = 64,
  localparam int PW      = $clog2(NPAT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [1:0]    wr_sel,
  input  logic [4:0]    wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [5:0]    str_len,
  input  logic [PW:0]   num_pat,
  input  logic          start,
  output logic          busy,
  output logic          done,
  sme_feeder_if.master  bus
);

  feeder_state_t st;

  logic [5:0]    idx;
  logic [5:0]    slen;
  logic [PW:0]   npat;
  logic [PW-1:0] slot;
  logic [7:0]    cnt;

  logic [7:0]    chardata_q;
  logic          isstring_q;
  logic          ispattern_q;
  logic          res_valid_q;
  logic [PW-1:0] res_slot_q;
  logic          res_match_q;
  logic [4:0]    res_index_q;
  logic          res_timeout_q;

  logic [NPAT-1:0][3:0] lens;
  logic [7:0]    str_rd;
  logic [7:0]    pat_rd;
  logic [7:0]    first_ch;
  logic [3:0]    plen;
  logic [PW:0]   nxt_first;
  logic [PW:0]   nxt_after;
  logic          idle;
  logic          go_ok;

  assign idle = (st == ST_IDLE);

  sme_feeder_mem #(.NPAT(NPAT)) u_mem (
    .clk      (clk),
    .reset    (reset),
    .we       (wr_en & idle),
    .sel      (wr_sel),
    .addr     (wr_addr),
    .data     (wr_data),
    .str_ra   (idle ? 5'd0 : idx[4:0]),
    .str_rd   (str_rd),
    .pat_slot (slot),
    .pat_ra   ((st == ST_GAP) ? 3'd0 : idx[2:0]),
    .pat_rd   (pat_rd),
    .lens     (lens)
  );

  // A write to str[0] in the start cycle lands on the same edge
  // that registers the first char, so forward it.
  assign first_ch =
    (wr_en && wr_sel == 2'b00 && wr_addr == 5'd0) ?
    wr_data : str_rd;

  assign go_ok = (str_len != 6'd0) &&
                 (int'(str_len) <= SME_STR_MAX) &&
                 (num_pat != '0);

  assign plen = (lens[slot] > 4'(SME_PAT_MAX)) ?
                4'(SME_PAT_MAX) : lens[slot];

  // First slot >= from, < lim with nonzero length; NPAT if none,
  // so bit PW set means "no more patterns".
  function automatic logic [PW:0] find_from(
    input logic [PW:0]          from,
    input logic [PW:0]          lim,
    input logic [NPAT-1:0][3:0] l
  );
    logic [PW:0] r;
    r = (PW+1)'(NPAT);
    for (int i = NPAT-1; i >= 0; i--)
      if (i >= int'(from) && i < int'(lim) && l[i] != 4'd0)
        r = (PW+1)'(i);
    return r;
  endfunction

  assign nxt_first = find_from('0, npat, lens);
  assign nxt_after = find_from({1'b0, slot} + 1'b1, npat, lens);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st            <= ST_IDLE;
      idx           <= '0;
      slen          <= '0;
      npat          <= '0;
      slot          <= '0;
      cnt           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      chardata_q    <= '0;
      isstring_q    <= 1'b0;
      ispattern_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_slot_q    <= '0;
      res_match_q   <= 1'b0;
      res_index_q   <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      done          <= 1'b0;
      res_valid_q   <= 1'b0;
      res_slot_q    <= '0;
      res_match_q   <= 1'b0;
      res_index_q   <= '0;
      res_timeout_q <= 1'b0;
      unique case (st)
        ST_IDLE: begin
          if (start) begin
            slen <= str_len;
            npat <= num_pat;
            slot <= '0;
            busy <= 1'b1;
            if (go_ok) begin
              st         <= ST_STR;
              isstring_q <= 1'b1;
              chardata_q <= first_ch;
              idx        <= 6'd1;
            end else begin
              st   <= ST_FIN;
              done <= 1'b1;
            end
          end
        end
        ST_STR: begin
          if (idx == slen) begin
            isstring_q <= 1'b0;
            chardata_q <= '0;
            idx        <= '0;
            if (!nxt_first[PW]) begin
              st   <= ST_GAP;
              slot <= nxt_first[PW-1:0];
            end else begin
              st   <= ST_FIN;
              done <= 1'b1;
            end
          end else begin
            chardata_q <= str_rd;
            idx        <= idx + 6'd1;
          end
        end
        ST_GAP: begin
          st          <= ST_PAT;
          ispattern_q <= 1'b1;
          chardata_q  <= pat_rd;
          idx         <= 6'd1;
        end
        ST_PAT: begin
          if (idx == {2'b00, plen}) begin
            st          <= ST_WAIT;
            ispattern_q <= 1'b0;
            chardata_q  <= '0;
            idx         <= '0;
            cnt         <= 8'd1;
          end else begin
            chardata_q <= pat_rd;
            idx        <= idx + 6'd1;
          end
        end
        ST_WAIT: begin
          if (bus.sme_valid) begin
            st          <= ST_RES;
            res_valid_q <= 1'b1;
            res_slot_q  <= slot;
            res_match_q <= bus.sme_match;
            res_index_q <= bus.sme_match_idx;
          end else if (cnt == TIMEOUT[7:0]) begin
            st            <= ST_RES;
            res_valid_q   <= 1'b1;
            res_slot_q    <= slot;
            res_timeout_q <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_RES: begin
          if (!nxt_after[PW]) begin
            st   <= ST_GAP;
            slot <= nxt_after[PW-1:0];
          end else begin
            st   <= ST_FIN;
            done <= 1'b1;
          end
        end
        ST_FIN: begin
          st   <= ST_IDLE;
          busy <= 1'b0;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign bus.chardata    = chardata_q;
  assign bus.isstring    = isstring_q;
  assign bus.ispattern   = ispattern_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_slot    = res_slot_q;
  assign bus.res_match   = res_match_q;
  assign bus.res_index   = res_index_q;
  assign bus.res_timeout = res_timeout_q;

endmodule

// File: tb/tb_sme_feeder.sv
// Bench for sme_feeder: per-cycle compare against a timeline model
// built from buffer contents, lengths and engine response delays.
module tb_sme_feeder;
  import sme_pkg::*;

  localparam int NPAT    = 4;
  localparam int PW      = 2;
  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [1:0]    wr_sel;
  logic [4:0]    wr_addr;
  logic [7:0]    wr_data;
  logic [5:0]    str_len;
  logic [PW:0]   num_pat;
  logic          start;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  sme_feeder_if #(.NPAT(NPAT)) bus ();

  sme_feeder #(.NPAT(NPAT), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .str_len (str_len),
    .num_pat (num_pat),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  typedef struct packed {
    logic          is;
    logic          ip;
    logic [7:0]    ch;
    logic          busy;
    logic          done;
    logic          rv;
    logic [PW-1:0] slot;
    logic          m;
    logic [4:0]    ix;
    logic          to;
  } obs_t;

  typedef struct packed {
    logic       w;
    logic       v;
    logic       m;
    logic [4:0] ix;
  } drv_t;

  logic [7:0] str_m [32];
  logic [7:0] pat_m [NPAT][8];
  logic [3:0] len_m [NPAT];
  int         dly_m [NPAT];
  logic       mt_m  [NPAT];
  logic [4:0] ix_m  [NPAT];

  obs_t exp_q [$];
  drv_t drv_q [$];
  int   rs_q  [$];

  int vectors = 0;
  int miscompares = 0;

  function automatic obs_t get_obs();
    obs_t o;
    o.is   = bus.isstring;
    o.ip   = bus.ispattern;
    o.ch   = bus.chardata;
    o.busy = busy;
    o.done = done;
    o.rv   = bus.res_valid;
    o.slot = bus.res_slot;
    o.m    = bus.res_match;
    o.ix   = bus.res_index;
    o.to   = bus.res_timeout;
    return o;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) str_m[i] = '0;
    for (int s = 0; s < NPAT; s++) begin
      len_m[s] = '0;
      for (int j = 0; j < 8; j++) pat_m[s][j] = '0;
    end
  endtask

  // Expected outputs for cycles T+1.. after a start at T.
  task automatic build(input int slen, input int np);
    obs_t o;
    drv_t d;
    int   l, nw;
    bit   hit;
    exp_q.delete();
    drv_q.delete();
    d = '0;
    if (slen < 1 || slen > 32 || np == 0) begin
      o = '0; o.busy = 1; o.done = 1;
      exp_q.push_back(o); drv_q.push_back(d);
      return;
    end
    for (int i = 0; i < slen; i++) begin
      o = '0; o.busy = 1; o.is = 1; o.ch = str_m[i];
      exp_q.push_back(o); drv_q.push_back(d);
    end
    for (int s = 0; s < np && s < NPAT; s++) begin
      l = (len_m[s] > 8) ? 8 : int'(len_m[s]);
      if (l == 0) continue;
      o = '0; o.busy = 1;
      exp_q.push_back(o); drv_q.push_back('0);
      for (int j = 0; j < l; j++) begin
        o = '0; o.busy = 1; o.ip = 1; o.ch = pat_m[s][j];
        exp_q.push_back(o); drv_q.push_back('0);
      end
      hit = (dly_m[s] >= 0 && dly_m[s] < TIMEOUT);
      nw = hit ? dly_m[s] + 1 : TIMEOUT;
      for (int w = 0; w < nw; w++) begin
        o = '0; o.busy = 1;
        d = '0; d.w = 1; d.v = hit && (w == dly_m[s]);
        d.m = mt_m[s]; d.ix = ix_m[s];
        exp_q.push_back(o); drv_q.push_back(d);
      end
      o = '0; o.busy = 1; o.rv = 1; o.slot = PW'(s);
      if (hit) begin o.m = mt_m[s]; o.ix = ix_m[s]; end
      else o.to = 1;
      exp_q.push_back(o); drv_q.push_back('0);
    end
    o = '0; o.busy = 1; o.done = 1;
    exp_q.push_back(o); drv_q.push_back('0);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [4:0] a,
                    input logic [7:0] dt);
    @(negedge clk);
    wr_en = 1; wr_sel = sel; wr_addr = a; wr_data = dt;
    @(negedge clk);
    wr_en = 0;
    case (sel)
      2'b00: str_m[a] = dt;
      2'b01: pat_m[a[4:3]][a[2:0]] = dt;
      2'b10: len_m[a[1:0]] = dt[3:0];
      default: ;
    endcase
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) wr(2'b00, 5'(i), s[i]);
  endtask

  task automatic load_pat(input int slot, input string s);
    for (int i = 0; i < s.len() && i < 8; i++)
      wr(2'b01, 5'(slot * 8 + i), s[i]);
    wr(2'b10, 5'(slot), 8'(s.len()));
  endtask

  task automatic run(input int slen, input int np, input bit noise,
                     input int abort_at, input int wr0,
                     output int res_off, output int done_off);
    obs_t o;
    drv_t d;
    bit   aborted;
    res_off = -1; done_off = -1; aborted = 0;
    rs_q.delete();
    @(negedge clk);
    str_len = 6'(slen); num_pat = (PW+1)'(np); start = 1;
    if (wr0 >= 0) begin
      wr_en = 1; wr_sel = 2'b00; wr_addr = '0; wr_data = 8'(wr0);
      str_m[0] = 8'(wr0);
    end
    build(slen, np);
    for (int k = 1; k <= exp_q.size(); k++) begin
      @(negedge clk);
      start = 0; wr_en = 0;
      bus.sme_valid = 0; bus.sme_match = 0; bus.sme_match_idx = '0;
      o = get_obs();
      vectors++;
      if (o !== exp_q[k-1]) begin
        miscompares++;
        $display("FAIL cycle T+%0d: got %h want %h", k, o, exp_q[k-1]);
      end
      if (o.rv) begin
        rs_q.push_back(int'(o.slot));
        if (res_off < 0) res_off = k;
      end
      if (o.done) done_off = k;
      if (k == abort_at) begin
        reset = 1;
        #1;
        chk("reset_drop", int'({busy, bus.isstring, bus.ispattern,
                                bus.res_valid}), 0);
        @(negedge clk);
        reset = 0;
        clear_model();
        aborted = 1;
        break;
      end
      d = drv_q[k-1];
      if (d.w) begin
        bus.sme_valid = d.v; bus.sme_match = d.m;
        bus.sme_match_idx = d.ix;
      end else if (noise) begin
        bus.sme_valid = ($urandom_range(0, 2) == 0);
        bus.sme_match = 1'($urandom);
        bus.sme_match_idx = 5'($urandom);
      end
      if (noise) begin
        wr_en = 1'($urandom); wr_sel = 2'($urandom);
        wr_addr = 5'($urandom); wr_data = 8'($urandom);
        start = ($urandom_range(0, 3) == 0);
        str_len = 6'($urandom_range(1, 32));
        num_pat = (PW+1)'($urandom_range(1, NPAT));
      end
    end
    if (!aborted) begin
      @(negedge clk);
      start = 0; wr_en = 0; bus.sme_valid = 0;
      o = get_obs();
      chk("idle_after", int'(o), 0);
    end
  endtask

  int r_off, d_off, ip_cnt, np, sl, wr0;

  initial begin
    reset = 1; wr_en = 0; wr_sel = '0; wr_addr = '0; wr_data = '0;
    str_len = '0; num_pat = '0; start = 0;
    bus.sme_valid = 0; bus.sme_match = 0; bus.sme_match_idx = '0;
    clear_model();
    #1;
    chk("reset_state", int'(get_obs()), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;

    // basic single pattern, response two cycles into WAIT
    load_str("abcdefg");
    load_pat(0, "cde");
    dly_m[0] = 2; mt_m[0] = 1; ix_m[0] = 5'd2;
    run(7, 1, 0, -1, -1, r_off, d_off);
    chk("t1_model_len", exp_q.size(), 16);
    chk("t1_model_gap", int'({exp_q[7].is, exp_q[7].ip}), 0);
    chk("t1_model_c", int'(exp_q[8].ch), 8'h63);
    chk("t1_res_off", r_off, 15);
    chk("t1_done_off", d_off, 16);
    chk("t1_nres", rs_q.size(), 1);

    // zero-length slot skipped
    load_pat(0, "xy");
    wr(2'b10, 5'd1, 8'd0);
    load_pat(2, "pqr");
    load_pat(3, "z");
    dly_m = '{1, 0, 0, 3};
    mt_m = '{0, 0, 1, 1};
    ix_m = '{5'd0, 5'd0, 5'd9, 5'd31};
    run(7, 4, 0, -1, -1, r_off, d_off);
    ip_cnt = 0;
    foreach (exp_q[i]) ip_cnt += int'(exp_q[i].ip);
    chk("t2_model_ipcnt", ip_cnt, 6);
    chk("t2_nres", rs_q.size(), 3);
    if (rs_q.size() == 3) begin
      chk("t2_slot_a", rs_q[0], 0);
      chk("t2_slot_b", rs_q[1], 2);
      chk("t2_slot_c", rs_q[2], 3);
    end

    // timeout
    load_str("wxyz");
    load_pat(0, "ab");
    dly_m[0] = -1;
    run(4, 1, 0, -1, -1, r_off, d_off);
    chk("t3_res_off", r_off, 72);
    chk("t3_done_off", d_off, 73);

    // degenerate starts
    run(0, 1, 0, -1, -1, r_off, d_off);
    chk("t4_len0_done", d_off, 1);
    chk("t4_len0_nres", rs_q.size(), 0);
    run(33, 1, 0, -1, -1, r_off, d_off);
    chk("t4_len33_done", d_off, 1);
    run(5, 0, 0, -1, -1, r_off, d_off);
    chk("t4_np0_done", d_off, 1);

    // noise during a run: writes, starts, stray valids ignored
    dly_m = '{4, 0, 2, 0};
    run(7, 4, 1, -1, -1, r_off, d_off);
    run(7, 4, 0, -1, -1, r_off, d_off);

    // reset in pattern burst, then a clean rerun
    load_str("abcdefg");
    load_pat(0, "cde");
    dly_m[0] = 2; mt_m[0] = 1; ix_m[0] = 5'd2;
    run(7, 1, 0, 10, -1, r_off, d_off);
    load_str("abcdefg");
    load_pat(0, "cde");
    run(7, 1, 0, -1, 8'h41, r_off, d_off);
    chk("t6_rerun_res", r_off, 15);
    if (rs_q.size() > 0) chk("t6_rerun_slot", rs_q[0], 0);

    // randomized runs
    for (int it = 0; it < 24; it++) begin
      for (int w = 0; w < 6; w++)
        wr(2'($urandom), 5'($urandom), 8'($urandom));
      for (int s = 0; s < NPAT; s++) begin
        wr(2'b10, 5'(s), 8'($urandom_range(0, 12)));
        case ($urandom_range(0, 5))
          0: dly_m[s] = -1;
          1: dly_m[s] = $urandom_range(60, 66);
          default: dly_m[s] = $urandom_range(0, 10);
        endcase
        mt_m[s] = 1'($urandom);
        ix_m[s] = 5'($urandom);
      end
      sl = ($urandom_range(0, 7) == 0) ?
           $urandom_range(32, 40) : $urandom_range(1, 32);
      np = $urandom_range(0, NPAT);
      wr0 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : -1;
      run(sl, np, 1'($urandom), -1, wr0, r_off, d_off);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
